// File: rtl/inst_sram_axi_rd.sv
// inst_sram_axi_rd: bridges the instruction fetch SRAM-like interface onto a
// single-beat AXI read channel. Each accepted fetch issues one AR transfer,
// and data returns to IF2 in request order. A cancel (IF flush) discards the
// responses of every read outstanding at the time of the flush.
//
// Handshake semantics: a transfer on any valid/ready pair happens in the cycle
// where both are high. Once arvalid is raised it stays high, with araddr
// stable, until arready is seen. inst_sram_addr_ok and inst_sram_data_ok are
// single-cycle strobes. rready is tied high, so every R beat is taken in the
// cycle it is offered.
module inst_sram_axi_rd #(
    parameter int         MAX_OUTSTANDING = 4,
    parameter logic [3:0] ARID            = 4'd0
) (
    input  logic        clk,
    input  logic        reset,

    // fetch side
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        cancel,
    output logic        busy,

    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // Counters must hold the value MAX_OUTSTANDING itself, hence the +1.
    localparam int            CW       = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] OUTS_MAX = CW'(MAX_OUTSTANDING);

    // AR channel state: idle, or holding an address until the slave takes it.
    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_PEND = 1'b1
    } ar_state_t;

    ar_state_t     ar_state;
    ar_state_t     ar_state_next;
    logic [31:0]   araddr_q;
    logic [CW-1:0] outs;
    logic [CW-1:0] outs_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_next;
    logic          addr_fire;
    logic          r_fire;
    logic          drop_now;

    // ID, length, size and burst never change: single 4-byte INCR beats.
    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign rready  = 1'b1;

    // Error reporting is out of scope, so these R fields carry no meaning here.
    logic unused_r;
    assign unused_r = ^{rid, rresp, rlast};

    assign arvalid = (ar_state == AR_PEND);
    assign araddr  = araddr_q;

    // Accept only when the AR slot is free and the outstanding budget is not
    // exhausted; registered outs is used so a return this cycle does not help.
    assign addr_fire         = inst_sram_req && !arvalid && (outs < OUTS_MAX);
    assign inst_sram_addr_ok = addr_fire;

    // A beat with nothing outstanding is stray (e.g. issued before a reset);
    // it is consumed by rready=1 but otherwise ignored.
    assign r_fire = rvalid && (outs != '0);

    // Beats belonging to requests outstanding at a flush are swallowed. The
    // cancel term covers the beat that arrives in the flush cycle itself.
    assign drop_now          = r_fire && (cancel || (drop != '0));
    assign inst_sram_data_ok = r_fire && !drop_now;
    assign inst_sram_rdata   = rdata;

    assign busy = (outs != '0);

    // AR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state <= AR_IDLE;
        end else begin
            ar_state <= ar_state_next;
        end
    end

    // AR next state: raise on accept, lower on the slave's handshake.
    always_comb begin
        ar_state_next = ar_state;
        case (ar_state)
            AR_IDLE: begin
                if (addr_fire) begin
                    ar_state_next = AR_PEND;
                end
            end
            AR_PEND: begin
                if (arready) begin
                    ar_state_next = AR_IDLE;
                end
            end
            default: ar_state_next = AR_IDLE;
        endcase
    end

    // Capture the word-aligned fetch address when a request is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= 32'd0;
        end else if (addr_fire) begin
            araddr_q <= {inst_sram_addr[31:2], 2'b00};
        end
    end

    // Outstanding and drop counters, next-state values.
    always_comb begin
        outs_next = outs + CW'(addr_fire) - CW'(r_fire);
        drop_next = drop;
        if (cancel) begin
            // Everything already outstanding is older than the flush; a
            // request accepted in this same cycle is not counted.
            drop_next = outs - CW'(r_fire);
        end else if (r_fire && (drop != '0)) begin
            drop_next = drop - CW'(1);
        end
    end

    // Outstanding and drop counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            outs <= '0;
            drop <= '0;
        end else begin
            outs <= outs_next;
            drop <= drop_next;
        end
    end

endmodule

// File: doc/inst_sram_axi_rd.md
# inst_sram_axi_rd

Instruction-side bridge between the fetch pipeline's SRAM-like request/response interface and a single-beat AXI read channel. It accepts fetch requests from IF1 (`req`/`addr`/`addr_ok`), issues one AXI AR transaction per accepted request, and returns read data to IF2 as an in-order `data_ok`/`rdata` stream. Up to `MAX_OUTSTANDING` reads may be in flight. A `cancel` input discards the responses to every request outstanding at the time of a pipeline flush.

## Interface
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unreturned reads; power of two, ≥1.
- `ARID`, 4'd0: constant AXI read ID.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `inst_sram_req` in 1: fetch request valid.
- `inst_sram_addr` in 32: fetch byte address.
- `inst_sram_addr_ok` out 1: request accepted this cycle.
- `inst_sram_data_ok` out 1: `inst_sram_rdata` valid this cycle.
- `inst_sram_rdata` out 32: instruction word.
- `cancel` in 1: drop responses of all outstanding requests (IF flush).
- `busy` out 1: any read outstanding.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1: AXI AR channel.
- `arready` in 1: AXI AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1: AXI R channel.
- `rready` out 1: AXI R channel.

## Operation
- Constants:
  - `arid=ARID`, `arlen=0`, `arsize=3'b010`, `arburst=2'b01`.
  - `rready=1`: every beat is accepted.
  - `rid`, `rresp` and `rlast` are ignored; error reporting is out of scope.
- Counters:
  - `outs` is the outstanding count, clog2(MAX_OUTSTANDING)+1 bits wide.
  - `drop` is the drop count, same width.
- `addr_fire = inst_sram_req && !arvalid && outs < MAX_OUTSTANDING`; `inst_sram_addr_ok = addr_fire`. The comparison uses registered `outs` with no same-cycle bypass.
- AR register behaviour:
  - On `addr_fire`: `araddr <= {inst_sram_addr[31:2],2'b00}` and `arvalid <= 1`.
  - `arvalid` holds, with `araddr` stable, until `arvalid && arready`, then drops to 0.
  - A new request is accepted only while `arvalid==0`.
- `r_fire = rvalid && outs != 0`. A beat arriving with `outs==0` is stray: it is consumed and ignored.
- `outs` next value:
  - `outs + addr_fire - r_fire`.
  - Simultaneous accept and return leaves `outs` unchanged.
- Drop logic:
  - `drop_now = r_fire && (cancel || drop != 0)`.
  - `inst_sram_data_ok = r_fire && !drop_now`.
  - `inst_sram_rdata = rdata`, combinational pass-through.
- `drop` next value:
  - If `cancel`: `outs - r_fire`. Requests accepted in the cancel cycle are not dropped.
  - Else if `r_fire && drop != 0`: `drop - 1`.
  - Else: unchanged.
- A second `cancel` while `drop != 0` reloads `drop` from `outs - r_fire`. This is the correct value because all outstanding requests are older than the cancel.
- `busy = (outs != 0)`.
- Responses return strictly in request order; the slave is required to return same-ID reads in order.

## Timing
- Reset values:
  - `arvalid=0`, `araddr=0`, `outs=0`, `drop=0`.
  - `inst_sram_addr_ok=0`, `inst_sram_data_ok=0`, `busy=0`.
  - `rready=1`, `arid=ARID`, `arlen=0`, `arsize=2`, `arburst=1`.
- Reset mid-operation: all state clears in one cycle, with no drain. Beats arriving afterwards with `outs==0` are ignored.
- Latency:
  - Request accepted in cycle T.
  - `arvalid=1` from T+1.
  - With zero-wait `arready` and a next-cycle R response: `rvalid` and `data_ok` at T+2.
- `data_ok` is combinational from `rvalid`, in the same cycle.
- Throughput: one accept every 2 cycles when `arready` is always high, because `addr_ok` is blocked while `arvalid` is set.
- Full condition: `outs==MAX_OUTSTANDING` forces `addr_ok=0` until a beat returns. `addr_ok` can reassert in the cycle after that return.
- `cancel` with a pending `arvalid`: the AR is still issued (AXI rule) and its beat is dropped.

## Test plan
- **Single fetch:** reset, then `req=1`, `addr=0xBFC00004`, with `arready=1`, `rvalid` one cycle after the AR handshake, `rdata=0x24080001` -> `addr_ok` at T, `araddr=0xBFC00004` and `arvalid` at T+1, `data_ok=1` with `rdata=0x24080001` at T+2, `busy` back to 0 at T+3.
- **Back-pressure/full:** `arready=1`, R held off, `req` held high -> exactly 4 accepts (addrs 0x0, 0x4, 0x8, 0xC) then `addr_ok=0`. Release one beat -> `addr_ok` reasserts on the next cycle. Beats return in address order.
- **AR stall:** `arready=0` for 5 cycles -> `arvalid` and `araddr` held constant, `addr_ok=0` throughout. The handshake occurs on the cycle `arready` rises.
- **Cancel:**
  - 3 reads outstanding, `cancel` pulsed while beat #1 arrives the same cycle -> beats #1-#3 give `data_ok=0`.
  - A request accepted in the cancel cycle returns with `data_ok=1`.
- **Cancel with pending AR:** cancel while `arvalid=1`, `arready=0` -> AR completes later, its beat is dropped, final `outs=0` and `drop=0`.
- **Reset mid-flight:** 2 reads outstanding, assert `reset` for 1 cycle, then drive a stray `rvalid` -> `data_ok` stays 0, `busy=0`, and the next request behaves as in the single-fetch case.
